// File: rtl/delivery_game_uc_pkg.sv
// Shared state codes for the delivery-game control unit; benches decode db_estado
// with the same UC_* names.
package delivery_game_uc_pkg;

  typedef enum logic [3:0] {
    UC_INICIAL       = 4'd0,
    UC_PREPARA       = 4'd1,
    UC_MEDE          = 4'd2,
    UC_ESPERA_MEDIDA = 4'd3,
    UC_JOGANDO       = 4'd4,
    UC_PAUSADO       = 4'd5,
    UC_FIM           = 4'd6
  } uc_state_t;

  function automatic logic is_em_jogo(input uc_state_t s);
    return (s == UC_PREPARA) || (s == UC_MEDE) || (s == UC_ESPERA_MEDIDA) ||
           (s == UC_JOGANDO) || (s == UC_PAUSADO);
  endfunction

endpackage

// File: rtl/delivery_game_uc_contador_m.sv
// Modulo-M counter with async reset, sync clear and enable; fim flags the last count.
module contador_m #(
  parameter int M = 16,
  parameter int N = (M > 1) ? $clog2(M) : 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  localparam logic [N-1:0] LAST = N'(M - 1);

  logic [N-1:0] q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (zera_s) begin
      q <= '0;
    end else if (conta) begin
      q <= (q == LAST) ? '0 : q + N'(1);
    end
  end

  assign fim = (q == LAST);

endmodule

// File: rtl/delivery_game_uc.sv
// Moore control unit sequencing the delivery-game datapath: start, speed
// measurement with timeout, play with periodic re-measurement, pause, game over.
module delivery_game_uc
  import delivery_game_uc_pkg::*;
#(
  parameter int REMEASURE_CYCLES = 50_000_000,
  parameter int TIMEOUT_CYCLES   = 5_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       pausar,
  input  logic       game_over,
  input  logic       velocity_ready,
  output logic       zera_fd,
  output logic       get_velocity,
  output logic       count_map,
  output logic       em_jogo,
  output logic       fim_jogo,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  uc_state_t estado, prox;
  logic first_done, timeout_q;
  logic set_first, set_timeout;
  logic zera_timers, conta_meas, conta_to;
  logic fim_meas, fim_to;

  // The re-measure timer parks on its last count, so a pause taken on that
  // cycle still re-measures right after resume.
  contador_m #(.M(REMEASURE_CYCLES)) u_timer_remede (
    .clock  (clock),
    .reset_n(reset_n),
    .zera_s (zera_timers),
    .conta  (conta_meas),
    .fim    (fim_meas)
  );

  contador_m #(.M(TIMEOUT_CYCLES)) u_timer_timeout (
    .clock  (clock),
    .reset_n(reset_n),
    .zera_s (zera_timers),
    .conta  (conta_to),
    .fim    (fim_to)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado <= UC_INICIAL;
    else          estado <= prox;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      first_done <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (estado == UC_PREPARA) begin
      first_done <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (set_first) begin
      first_done <= 1'b1;
      timeout_q  <= set_timeout;
    end
  end

  always_comb begin
    prox        = estado;
    set_first   = 1'b0;
    set_timeout = 1'b0;
    case (estado)
      UC_INICIAL:       if (iniciar) prox = UC_PREPARA;
      UC_PREPARA:       prox = UC_MEDE;
      UC_MEDE:          prox = (first_done && game_over) ? UC_FIM : UC_ESPERA_MEDIDA;
      UC_ESPERA_MEDIDA: begin
        if (first_done && game_over) begin
          prox = UC_FIM;
        end else if (velocity_ready) begin
          prox      = UC_JOGANDO;
          set_first = 1'b1;
        end else if (fim_to) begin
          prox        = UC_JOGANDO;
          set_first   = 1'b1;
          set_timeout = 1'b1;
        end
      end
      UC_JOGANDO: begin
        if (game_over)     prox = UC_FIM;
        else if (pausar)   prox = UC_PAUSADO;
        else if (fim_meas) prox = UC_MEDE;
      end
      UC_PAUSADO: begin
        if (pausar)       prox = UC_JOGANDO;
        else if (iniciar) prox = UC_PREPARA;
      end
      UC_FIM:           if (iniciar) prox = UC_PREPARA;
      default:          prox = UC_INICIAL;
    endcase
  end

  always_comb begin
    zera_fd      = (estado == UC_PREPARA);
    get_velocity = (estado == UC_MEDE);
    count_map    = (estado == UC_JOGANDO) ||
                   (first_done && ((estado == UC_MEDE) || (estado == UC_ESPERA_MEDIDA)));
    em_jogo      = is_em_jogo(estado);
    fim_jogo     = (estado == UC_FIM);
    zera_timers  = (estado == UC_PREPARA) || (estado == UC_MEDE);
    conta_meas   = (estado == UC_JOGANDO) && !fim_meas;
    conta_to     = (estado == UC_ESPERA_MEDIDA);
    db_estado    = estado;
  end

  assign db_timeout = timeout_q;

endmodule

// File: tb/tb_delivery_game_uc.sv
// Bench for delivery_game_uc: vector table, directed multi-cycle sequences and
// random stimulus against a cycle-counting reference model.
module tb_delivery_game_uc;
  import delivery_game_uc_pkg::*;

  localparam int REM = 20;
  localparam int TO  = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic iniciar = 1'b0, pausar = 1'b0, game_over = 1'b0, velocity_ready = 1'b0;
  logic zera_fd, get_velocity, count_map, em_jogo, fim_jogo, db_timeout;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  // Reference model: state number, flags, and plain cycle counts.
  int ms, played, waited;
  bit mf, mt;

  delivery_game_uc #(.REMEASURE_CYCLES(REM), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .pausar(pausar),
    .game_over(game_over), .velocity_ready(velocity_ready), .zera_fd(zera_fd),
    .get_velocity(get_velocity), .count_map(count_map), .em_jogo(em_jogo),
    .fim_jogo(fim_jogo), .db_timeout(db_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic ini, pau, go, vr;
    logic [3:0] est;
    logic cm, tmo;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [9:0] dut_vec();
    return {db_estado, zera_fd, get_velocity, count_map, em_jogo, fim_jogo, db_timeout};
  endfunction

  function automatic logic [9:0] model_vec();
    logic cm;
    cm = (ms == 4) || (((ms == 2) || (ms == 3)) && mf);
    return {4'(ms), ms == 1, ms == 2, cm, (ms >= 1 && ms <= 5), ms == 6, mt};
  endfunction

  task automatic model_reset();
    ms = 0; mf = 0; mt = 0; played = 0; waited = 0;
  endtask

  task automatic model_step(input bit ini, input bit pau, input bit go, input bit vr);
    case (ms)
      0: if (ini) ms = 1;
      1: begin mf = 0; mt = 0; played = 0; ms = 2; end
      2: begin waited = 0; ms = (mf && go) ? 6 : 3; end
      3: begin
        waited++;
        if (mf && go) ms = 6;
        else if (vr) begin ms = 4; mt = 0; mf = 1; end
        else if (waited >= TO) begin ms = 4; mt = 1; mf = 1; end
      end
      4: begin
        played++;
        if (go) ms = 6;
        else if (pau) ms = 5;
        else if (played >= REM) begin ms = 2; played = 0; end
      end
      5: if (pau) ms = 4; else if (ini) ms = 1;
      6: if (ini) ms = 1;
      default: ms = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_step(iniciar, pausar, game_over, velocity_ready);
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic wait_state(input logic [3:0] code, input int budget,
                            output int n, output int cm_low);
    n = 0;
    cm_low = 0;
    while (db_estado !== code && n < budget) begin
      tick();
      n++;
      if (!count_map) cm_low++;
    end
  endtask

  initial begin
    int n, cml, zc, gc;

    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0};

    model_reset();
    repeat (3) tick();
    chk("reset_state", dut_vec(), 10'd0);
    reset_n = 1'b1;

    zc = 0;
    gc = 0;
    for (int i = 0; i < 9; i++) begin
      iniciar = tbl[i].ini; pausar = tbl[i].pau;
      game_over = tbl[i].go; velocity_ready = tbl[i].vr;
      tick();
      zc += int'(zera_fd);
      gc += int'(get_velocity);
      chk($sformatf("tbl%0d_estado", i), db_estado, tbl[i].est);
      chk($sformatf("tbl%0d_count_map", i), count_map, tbl[i].cm);
      chk($sformatf("tbl%0d_timeout", i), db_timeout, tbl[i].tmo);
      iniciar = 0; pausar = 0; game_over = 0; velocity_ready = 0;
    end
    chk("zera_fd_cycles", zc, 1);
    chk("get_velocity_cycles", gc, 1);

    // Re-measure after 20 play cycles; 2 already elapsed in the table.
    wait_state(UC_MEDE, 100, n, cml);
    chk("remeasure_latency", n, 18);
    chk("remeasure_count_map_low", cml, 0);

    // Timeout path.
    tick();
    chk("espera_after_mede", db_estado, UC_ESPERA_MEDIDA);
    chk("count_map_remeasure", count_map, 1);
    wait_state(UC_JOGANDO, 100, n, cml);
    chk("timeout_latency", n, TO);
    chk("timeout_flag_set", db_timeout, 1);

    // Successful measurement clears the sticky timeout.
    wait_state(UC_MEDE, 100, n, cml);
    chk("remeasure_after_timeout", n, REM);
    tick(); tick(); tick();
    velocity_ready = 1; tick(); velocity_ready = 0;
    chk("ready_to_jogando", db_estado, UC_JOGANDO);
    chk("timeout_flag_cleared", db_timeout, 0);

    // Pause at play cycle 10, with game_over ignored while paused.
    repeat (9) tick();
    pausar = 1; tick(); pausar = 0;
    chk("pause_state", db_estado, UC_PAUSADO);
    chk("pause_count_map", count_map, 0);
    game_over = 1;
    repeat (10) tick();
    game_over = 0;
    repeat (20) tick();
    chk("still_paused", db_estado, UC_PAUSADO);
    pausar = 1; tick(); pausar = 0;
    chk("resume_state", db_estado, UC_JOGANDO);
    wait_state(UC_MEDE, 100, n, cml);
    chk("remeasure_after_resume", n, 10);

    // game_over and pausar together go to FIM.
    tick();
    velocity_ready = 1; tick(); velocity_ready = 0;
    game_over = 1; pausar = 1; tick(); pausar = 0;
    chk("simul_fim", db_estado, UC_FIM);
    chk("fim_jogo_high", fim_jogo, 1);
    chk("em_jogo_low", em_jogo, 0);
    pausar = 1; velocity_ready = 1; tick(); pausar = 0; velocity_ready = 0;
    chk("fim_ignores_inputs", db_estado, UC_FIM);
    game_over = 0;
    iniciar = 1; tick(); iniciar = 0;
    chk("fim_restart", db_estado, UC_PREPARA);

    // Asynchronous reset during a re-measurement wait.
    tick(); tick();
    velocity_ready = 1; tick(); velocity_ready = 0;
    wait_state(UC_MEDE, 100, n, cml);
    chk("remeasure_before_reset", n, REM);
    tick();
    chk("espera_count_map", count_map, 1);
    @(negedge clock);
    reset_n = 0;
    #1;
    model_reset();
    chk("async_reset_outputs", dut_vec(), 10'd0);
    tick(); tick();
    @(negedge clock);
    reset_n = 1;
    velocity_ready = 1; tick(); velocity_ready = 0;
    chk("late_ready_ignored", db_estado, UC_INICIAL);

    // Random stimulus against the reference model.
    for (int c = 0; c < 3000; c++) begin
      iniciar = ($urandom_range(0, 99) < 4);
      pausar = ($urandom_range(0, 99) < 6);
      velocity_ready = ($urandom_range(0, 99) < 12);
      if ($urandom_range(0, 99) < 3) game_over = ~game_over;
      reset_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    reset_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
